// File: rtl/mem_responder.sv
// Load/store memory target: one request at a time, programmable stall, byte-lane word array,
// ARMv4-style sub-word extension and rotated unaligned word loads.
module mem_responder #(
    parameter int DEPTH       = 1024,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int         AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0] CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS, S_RESP} state_t;

    state_t      state_q;
    logic [3:0]  cnt_q;
    logic        req_ready_q;
    logic        resp_valid_q;
    logic        err_q;
    logic [31:0] rdata_q;

    logic        we_q;
    logic        signed_q;
    logic [1:0]  size_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;

    logic [3:0][7:0] mem_q [DEPTH];

    logic [AW-1:0] idx;
    logic [31:0]   word;
    logic [7:0]    byte_sel;
    logic [15:0]   half_sel;
    logic [31:0]   load_d;
    logic [31:0]   rdata_d;
    logic          err_d;
    logic [3:0]    be;
    logic [31:0]   wlanes;
    logic          do_write;

    assign idx  = addr_q[AW+1:2];
    assign word = mem_q[idx];

    always_comb begin
        err_d    = (size_q == 2'b11) || (size_q == 2'b01 && addr_q[0]) ||
                   ({2'b00, addr_q[31:2]} >= 32'(DEPTH));
        byte_sel = word[8*addr_q[1:0] +: 8];
        half_sel = addr_q[1] ? word[31:16] : word[15:0];
        load_d   = word;
        be       = 4'b1111;
        wlanes   = wdata_q;
        case (size_q)
            2'b00: begin
                load_d = {{24{signed_q & byte_sel[7]}}, byte_sel};
                be     = 4'b0001 << addr_q[1:0];
                wlanes = {4{wdata_q[7:0]}};
            end
            2'b01: begin
                load_d = {{16{signed_q & half_sel[15]}}, half_sel};
                be     = addr_q[1] ? 4'b1100 : 4'b0011;
                wlanes = {2{wdata_q[15:0]}};
            end
            default: begin
                // Unaligned word loads rotate right by the byte offset (ARMv4 LDR behaviour)
                case (addr_q[1:0])
                    2'd0:    load_d = word;
                    2'd1:    load_d = {word[7:0],  word[31:8]};
                    2'd2:    load_d = {word[15:0], word[31:16]};
                    default: load_d = {word[23:0], word[31:24]};
                endcase
            end
        endcase
        rdata_d  = (err_d || we_q) ? 32'd0 : load_d;
        do_write = (state_q == S_ACCESS) && we_q && !err_d;
    end

    always_ff @(posedge clk) begin
        if (do_write) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem_q[idx][i] <= wlanes[8*i +: 8];
            end
        end
    end

    // Request fields are captured only on the accept edge
    always_ff @(posedge clk) begin
        if (state_q == S_IDLE && req_valid) begin
            we_q     <= req_we;
            size_q   <= req_size;
            signed_q <= req_signed;
            addr_q   <= req_addr;
            wdata_q  <= req_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= 4'd0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            rdata_q      <= 32'd0;
            err_q        <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (req_valid) begin
                        req_ready_q <= 1'b0;
                        cnt_q       <= CNT_INIT;
                        state_q     <= (WAIT_CYCLES > 0) ? S_WAIT : S_ACCESS;
                    end
                end
                S_WAIT: begin
                    if (cnt_q == 4'd0) state_q <= S_ACCESS;
                    else               cnt_q   <= cnt_q - 4'd1;
                end
                S_ACCESS: begin
                    rdata_q      <= rdata_d;
                    err_q        <= err_d;
                    resp_valid_q <= 1'b1;
                    state_q      <= S_RESP;
                end
                default: begin
                    if (resp_ready) begin
                        resp_valid_q <= 1'b0;
                        rdata_q      <= 32'd0;
                        err_q        <= 1'b0;
                        req_ready_q  <= 1'b1;
                        state_q      <= S_IDLE;
                    end
                end
            endcase
        end
    end

    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: expected responses are queued at issue and popped on response.
module tb_mem_responder;

    localparam int DEPTH       = 1024;
    localparam int WAIT_CYCLES = 2;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;

    mem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(WAIT_CYCLES)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err)
    );

    typedef struct {
        logic        we;
        logic [1:0]  sz;
        logic        sg;
        logic [31:0] a;
        logic [31:0] wd;
        logic [31:0] er;
        logic        ee;
    } op_t;

    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;
    int          last_acc;
    logic [32:0] exp_q[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (req_ready === 1'b1 && resp_valid === 1'b1) begin
            bad++;
            $display("FAIL overlap req_ready=1 resp_valid=1 at cycle %0d, required never both", cyc);
        end
    end

    function automatic op_t mk(input logic we, input logic [1:0] sz, input logic sg,
                               input logic [31:0] a, input logic [31:0] wd,
                               input logic [31:0] er, input logic ee);
        op_t o;
        o.we = we; o.sz = sz; o.sg = sg; o.a = a; o.wd = wd; o.er = er; o.ee = ee;
        return o;
    endfunction

    task automatic issue(input op_t o);
        int n;
        exp_q.push_back({o.ee, o.er});
        @(negedge clk);
        req_we = o.we; req_size = o.sz; req_signed = o.sg;
        req_addr = o.a; req_wdata = o.wd; req_valid = 1'b1;
        n = 0;
        while (req_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (req_ready !== 1'b1) begin
            bad++;
            $display("FAIL accept_timeout req_ready=%b required 1", req_ready);
        end
        @(posedge clk);
        last_acc = cyc;
        #1 req_valid = 1'b0;
    endtask

    task automatic collect(output logic [31:0] rd, output logic e, output int lat, output bit to);
        lat = 0;
        to  = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (resp_valid === 1'b1) begin
                to = 1'b0;
                break;
            end
            @(posedge clk);
            lat++;
        end
        rd = resp_rdata;
        e  = resp_err;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b10; req_signed = 1'b0;
        req_addr = 32'd0; req_wdata = 32'd0; resp_ready = 1'b1;
        #2 rst = 1'b0;
        #10;
        total++;
        if (req_ready !== 1'b1) begin bad++; $display("FAIL reset_req_ready got %b want 1", req_ready); end
        total++;
        if (resp_valid !== 1'b0) begin bad++; $display("FAIL reset_resp_valid got %b want 0", resp_valid); end
        total++;
        if (resp_rdata !== 32'd0 || resp_err !== 1'b0) begin
            bad++; $display("FAIL reset_resp got rdata=%08h err=%b want 0/0", resp_rdata, resp_err);
        end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_word;
        logic [31:0] rd; logic e; int lat; bit to; logic [32:0] ex;
        op_t ops[$];
        ops.push_back(mk(1, 2'b10, 0, 32'h10, 32'hDEADBEEF, 32'h0, 0));
        ops.push_back(mk(0, 2'b10, 0, 32'h10, 32'h0, 32'hDEADBEEF, 0));
        for (int i = 0; i < ops.size(); i++) begin
            issue(ops[i]);
            collect(rd, e, lat, to);
            ex = exp_q.pop_front();
            total++;
            if (to || {e, rd} !== ex) begin
                bad++;
                $display("FAIL word[%0d] got err=%b rdata=%08h want err=%b rdata=%08h", i, e, rd, ex[32], ex[31:0]);
            end
            total++;
            if (lat != WAIT_CYCLES + 1) begin
                bad++;
                $display("FAIL word_latency[%0d] got %0d edges want %0d", i, lat, WAIT_CYCLES + 1);
            end
        end
    endtask

    task automatic test_subword_load;
        logic [31:0] rd; logic e; int lat; bit to; logic [32:0] ex;
        op_t ops[$];
        ops.push_back(mk(1, 2'b10, 0, 32'h20, 32'h80F17F01, 32'h0, 0));
        ops.push_back(mk(0, 2'b00, 0, 32'h21, 32'h0, 32'h0000007F, 0));
        ops.push_back(mk(0, 2'b00, 1, 32'h23, 32'h0, 32'hFFFFFF80, 0));
        ops.push_back(mk(0, 2'b00, 0, 32'h23, 32'h0, 32'h00000080, 0));
        ops.push_back(mk(0, 2'b01, 1, 32'h22, 32'h0, 32'hFFFF80F1, 0));
        ops.push_back(mk(0, 2'b01, 0, 32'h20, 32'h0, 32'h00007F01, 0));
        ops.push_back(mk(0, 2'b01, 1, 32'h20, 32'h0, 32'h00007F01, 0));
        for (int i = 0; i < ops.size(); i++) begin
            issue(ops[i]);
            collect(rd, e, lat, to);
            ex = exp_q.pop_front();
            total++;
            if (to || {e, rd} !== ex) begin
                bad++;
                $display("FAIL subload[%0d] got err=%b rdata=%08h want err=%b rdata=%08h", i, e, rd, ex[32], ex[31:0]);
            end
        end
    endtask

    task automatic test_subword_store;
        logic [31:0] rd; logic e; int lat; bit to; logic [32:0] ex;
        op_t ops[$];
        ops.push_back(mk(1, 2'b10, 0, 32'h30, 32'h11223344, 32'h0, 0));
        ops.push_back(mk(1, 2'b00, 0, 32'h31, 32'h123456AA, 32'h0, 0));
        ops.push_back(mk(1, 2'b01, 0, 32'h32, 32'h9999BBCC, 32'h0, 0));
        ops.push_back(mk(0, 2'b10, 0, 32'h30, 32'h0, 32'hBBCCAA44, 0));
        ops.push_back(mk(1, 2'b10, 0, 32'h37, 32'hCAFEF00D, 32'h0, 0));
        ops.push_back(mk(0, 2'b10, 0, 32'h34, 32'h0, 32'hCAFEF00D, 0));
        for (int i = 0; i < ops.size(); i++) begin
            issue(ops[i]);
            collect(rd, e, lat, to);
            ex = exp_q.pop_front();
            total++;
            if (to || {e, rd} !== ex) begin
                bad++;
                $display("FAIL substore[%0d] got err=%b rdata=%08h want err=%b rdata=%08h", i, e, rd, ex[32], ex[31:0]);
            end
        end
    endtask

    task automatic test_unaligned_err;
        logic [31:0] rd; logic e; int lat; bit to; logic [32:0] ex;
        op_t ops[$];
        ops.push_back(mk(1, 2'b10, 0, 32'h40, 32'h11223344, 32'h0, 0));
        ops.push_back(mk(0, 2'b10, 0, 32'h41, 32'h0, 32'h44112233, 0));
        ops.push_back(mk(0, 2'b10, 0, 32'h42, 32'h0, 32'h33441122, 0));
        ops.push_back(mk(0, 2'b10, 0, 32'h43, 32'h0, 32'h22334411, 0));
        ops.push_back(mk(1, 2'b01, 0, 32'h43, 32'h0000FFFF, 32'h0, 1));
        ops.push_back(mk(0, 2'b01, 0, 32'h43, 32'h0, 32'h0, 1));
        ops.push_back(mk(0, 2'b10, 0, 32'h40, 32'h0, 32'h11223344, 0));
        ops.push_back(mk(1, 2'b10, 0, 32'h0, 32'hA5A5A5A5, 32'h0, 0));
        ops.push_back(mk(1, 2'b10, 0, 32'(4 * DEPTH), 32'h5A5A5A5A, 32'h0, 1));
        ops.push_back(mk(0, 2'b10, 0, 32'(4 * DEPTH), 32'h0, 32'h0, 1));
        ops.push_back(mk(0, 2'b10, 0, 32'h0, 32'h0, 32'hA5A5A5A5, 0));
        ops.push_back(mk(1, 2'b10, 0, 32'(4 * DEPTH - 4), 32'h0BADF00D, 32'h0, 0));
        ops.push_back(mk(0, 2'b10, 0, 32'(4 * DEPTH - 4), 32'h0, 32'h0BADF00D, 0));
        ops.push_back(mk(0, 2'b11, 0, 32'h40, 32'h0, 32'h0, 1));
        ops.push_back(mk(1, 2'b11, 0, 32'h40, 32'hFFFFFFFF, 32'h0, 1));
        ops.push_back(mk(0, 2'b10, 0, 32'h40, 32'h0, 32'h11223344, 0));
        for (int i = 0; i < ops.size(); i++) begin
            issue(ops[i]);
            collect(rd, e, lat, to);
            ex = exp_q.pop_front();
            total++;
            if (to || {e, rd} !== ex) begin
                bad++;
                $display("FAIL unaligned_err[%0d] got err=%b rdata=%08h want err=%b rdata=%08h", i, e, rd, ex[32], ex[31:0]);
            end
        end
    endtask

    task automatic test_backpressure;
        logic [31:0] rd; logic e; int lat; bit to; logic [32:0] ex;
        resp_ready = 1'b0;
        issue(mk(0, 2'b10, 0, 32'h10, 32'h0, 32'hDEADBEEF, 0));
        collect(rd, e, lat, to);
        ex = exp_q.pop_front();
        total++;
        if (to || {e, rd} !== ex) begin
            bad++;
            $display("FAIL bp_first got err=%b rdata=%08h want err=%b rdata=%08h", e, rd, ex[32], ex[31:0]);
        end
        @(negedge clk);
        req_we = 1'b0; req_size = 2'b10; req_signed = 1'b0; req_addr = 32'h20; req_valid = 1'b1;
        exp_q.push_back({1'b0, 32'h80F17F01});
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            total++;
            if (resp_valid !== 1'b1 || resp_rdata !== 32'hDEADBEEF || resp_err !== 1'b0 || req_ready !== 1'b0) begin
                bad++;
                $display("FAIL bp_hold[%0d] got valid=%b rdata=%08h err=%b ready=%b want 1/deadbeef/0/0",
                         k, resp_valid, resp_rdata, resp_err, req_ready);
            end
        end
        resp_ready = 1'b1;
        @(negedge clk);
        total++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b1 || resp_rdata !== 32'd0) begin
            bad++;
            $display("FAIL bp_release got valid=%b ready=%b rdata=%08h want 0/1/00000000",
                     resp_valid, req_ready, resp_rdata);
        end
        @(posedge clk);
        #1 req_valid = 1'b0;
        req_addr = 32'h10;
        collect(rd, e, lat, to);
        ex = exp_q.pop_front();
        total++;
        if (to || {e, rd} !== ex) begin
            bad++;
            $display("FAIL bp_second got err=%b rdata=%08h want err=%b rdata=%08h", e, rd, ex[32], ex[31:0]);
        end
    endtask

    task automatic test_async_reset;
        logic [31:0] rd; logic e; int lat; bit to; logic [32:0] ex;
        issue(mk(1, 2'b10, 0, 32'h50, 32'h12345678, 32'h0, 0));
        collect(rd, e, lat, to);
        ex = exp_q.pop_front();
        total++;
        if (to || {e, rd} !== ex) begin
            bad++;
            $display("FAIL ar_prefill got err=%b rdata=%08h want err=%b rdata=%08h", e, rd, ex[32], ex[31:0]);
        end
        issue(mk(1, 2'b00, 0, 32'h50, 32'h00000055, 32'h0, 0));
        void'(exp_q.pop_front());
        #2 rst = 1'b0;
        #1;
        total++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
            bad++;
            $display("FAIL ar_wait got ready=%b valid=%b want 1/0", req_ready, resp_valid);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        resp_ready = 1'b0;
        issue(mk(0, 2'b10, 0, 32'h50, 32'h0, 32'h12345678, 0));
        collect(rd, e, lat, to);
        ex = exp_q.pop_front();
        total++;
        if (to || {e, rd} !== ex) begin
            bad++;
            $display("FAIL ar_reload got err=%b rdata=%08h want err=%b rdata=%08h", e, rd, ex[32], ex[31:0]);
        end
        #2 rst = 1'b0;
        #1;
        total++;
        if (resp_valid !== 1'b0 || resp_rdata !== 32'd0 || resp_err !== 1'b0 || req_ready !== 1'b1) begin
            bad++;
            $display("FAIL ar_resp got valid=%b rdata=%08h err=%b ready=%b want 0/00000000/0/1",
                     resp_valid, resp_rdata, resp_err, req_ready);
        end
        @(negedge clk);
        rst = 1'b1;
        resp_ready = 1'b1;
    endtask

    task automatic test_back_to_back;
        logic [31:0] rd; logic e; int lat; bit to; logic [32:0] ex;
        int prev;
        logic [31:0] addrs [3] = '{32'h10, 32'h20, 32'h30};
        logic [31:0] vals  [3] = '{32'hDEADBEEF, 32'h80F17F01, 32'hBBCCAA44};
        prev = 0;
        for (int i = 0; i < 3; i++) begin
            issue(mk(0, 2'b10, 0, addrs[i], 32'h0, vals[i], 0));
            if (i > 0) begin
                total++;
                if (last_acc - prev != WAIT_CYCLES + 3) begin
                    bad++;
                    $display("FAIL b2b_period[%0d] got %0d cycles want %0d", i, last_acc - prev, WAIT_CYCLES + 3);
                end
            end
            prev = last_acc;
            collect(rd, e, lat, to);
            ex = exp_q.pop_front();
            total++;
            if (to || {e, rd} !== ex) begin
                bad++;
                $display("FAIL b2b[%0d] got err=%b rdata=%08h want err=%b rdata=%08h", i, e, rd, ex[32], ex[31:0]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_word();
        test_subword_load();
        test_subword_store();
        test_unaligned_err();
        test_backpressure();
        test_async_reset();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
